// File: rtl/seg7_readback.sv
// Readback decoder for active-low gfedcba 7-segment buses: snapshot on start, one digit per clock.
// Optional SEG7_RB_STABLE_EN adds a CONFIRM state that waits for the bus to settle before scanning.
module seg7_readback #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7*NUM_DIGITS-1:0]   segs,
    output logic                      busy,
    output logic                      valid,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     err_mask,
    output logic                      unstable
);

    localparam int unsigned SEG_W = 7 * NUM_DIGITS;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
`ifdef SEG7_RB_STABLE_EN
        ,
        CONFIRM = 2'd3
`endif
    } state_t;

    state_t              state, state_d;
    logic [SEG_W-1:0]    snap, snap_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [VAL_W-1:0]    work_val, work_val_d;
    logic [NUM_DIGITS-1:0] work_mask, work_mask_d;
    logic                busy_d, valid_d, unstable_d;
    logic [VAL_W-1:0]    value_d;
    logic [NUM_DIGITS-1:0] err_mask_d;
    logic [6:0]          cur_glyph;
    logic [3:0]          dec_nib;
    logic                dec_bad;
    logic                accept;
`ifdef SEG7_RB_STABLE_EN
    logic [1:0]          retry, retry_d;
    logic                work_unst, work_unst_d;
`endif

    // Select the snapshot digit currently addressed by the scan index.
    always_comb begin
        cur_glyph = 7'h7F;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) cur_glyph = snap[7*i +: 7];
        end
    end

    // Shared glyph decoder; unknown patterns flag an error and yield nibble 0.
    always_comb begin
        dec_bad = 1'b0;
        case (cur_glyph)
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_bad = 1'b1;
            end
        endcase
    end

    // Next-state and datapath; DONE may accept a new start in the same cycle it reports.
    always_comb begin
        state_d     = state;
        snap_d      = snap;
        idx_d       = idx;
        work_val_d  = work_val;
        work_mask_d = work_mask;
        valid_d     = 1'b0;
        value_d     = value;
        err_mask_d  = err_mask;
        unstable_d  = unstable;
        accept      = 1'b0;
`ifdef SEG7_RB_STABLE_EN
        retry_d     = retry;
        work_unst_d = work_unst;
`endif

        case (state)
            IDLE: begin
                accept = start;
`ifdef SEG7_RB_STABLE_EN
                if (start) unstable_d = 1'b0;
`endif
            end
            SCAN: begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (idx == IDX_W'(i)) begin
                        work_val_d[4*i +: 4] = dec_nib;
                        work_mask_d[i]       = dec_bad;
                    end
                end
                if (idx == LAST_IDX) state_d = DONE;
                else                 idx_d   = idx + IDX_W'(1);
            end
            DONE: begin
                valid_d    = 1'b1;
                value_d    = work_val;
                err_mask_d = work_mask;
`ifdef SEG7_RB_STABLE_EN
                unstable_d = work_unst;
`endif
                state_d    = IDLE;
                accept     = start;
            end
`ifdef SEG7_RB_STABLE_EN
            CONFIRM: begin
                if (segs == snap) begin
                    state_d = SCAN;
                end else if (retry == 2'd3) begin
                    state_d     = SCAN;
                    work_unst_d = 1'b1;
                end else begin
                    snap_d  = segs;
                    retry_d = retry + 2'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            snap_d      = segs;
            idx_d       = '0;
            work_val_d  = '0;
            work_mask_d = '0;
`ifdef SEG7_RB_STABLE_EN
            retry_d     = 2'd0;
            work_unst_d = 1'b0;
            state_d     = CONFIRM;
`else
            state_d     = SCAN;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= '0;
            work_val  <= '0;
            work_mask <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            value     <= '0;
            err_mask  <= '0;
            unstable  <= 1'b0;
`ifdef SEG7_RB_STABLE_EN
            retry     <= 2'd0;
            work_unst <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            snap      <= snap_d;
            idx       <= idx_d;
            work_val  <= work_val_d;
            work_mask <= work_mask_d;
            busy      <= busy_d;
            valid     <= valid_d;
            value     <= value_d;
            err_mask  <= err_mask_d;
            unstable  <= unstable_d;
`ifdef SEG7_RB_STABLE_EN
            retry     <= retry_d;
            work_unst <= work_unst_d;
`endif
        end
    end

endmodule
